i2s_clock_sequencer: RTL and testbench
======================================

I2S_CLOCK_SEQUENCER -- requirements
Module: i2s_clock_sequencer

Interface
REQ-001 SHALL have parameter MCLK_DIV, default 2: SYS_CLK cycles per MCLK half-period (>=1).
REQ-002 SHALL have parameter SCLK_RATIO, default 4: MCLK periods per SCLK period (even, >=2).
REQ-003 SHALL have parameter WARMUP_MCLK, default 32: MCLK periods run before SCLK/LRCK start (>=1).
REQ-004 SYS_CLK  input  1  sole clock; all logic rises on it.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 EN  input  1  request to run the I2S clocks.
REQ-007 MCLK  output  1  master clock to the PMOD, fanned to rx_MCLK/tx_MCLK at top level.
REQ-008 SCLK  output  1  bit clock, fanned to rx_SCLK/tx_SCLK.
REQ-009 LRCK  output  1  word select: 0 = left, 1 = right; fanned to rx_LRCK/tx_LRCK.
REQ-010 SCLK_RISE  output  1  one-cycle strobe: SDIN sample point.
REQ-011 SCLK_FALL  output  1  one-cycle strobe: SDOUT shift point.
REQ-012 FRAME_START  output  1  one-cycle strobe at slot 0 of each frame.
REQ-013 SLOT  output  6  current bit slot, 0..63, within the frame.
REQ-014 RUNNING  output  1  high while SCLK/LRCK are active (RUN or DRAIN).

Function
REQ-015 Define P = 2*MCLK_DIV and S = P*SCLK_RATIO; phase counter ph counts 0..S-1 in SYS_CLK cycles.
REQ-016 All outputs SHALL be registered.
REQ-017 States SHALL be IDLE, WARMUP, RUN and DRAIN.
REQ-018 IDLE: MCLK, SCLK, LRCK, all strobes, SLOT and RUNNING SHALL be 0.
REQ-019 IDLE with EN=1 at edge k SHALL enter WARMUP at k+1 with ph=0.
REQ-020 In WARMUP, RUN and DRAIN, MCLK SHALL be 0 for (ph mod P) < MCLK_DIV and 1 otherwise.
REQ-021 WARMUP SHALL hold SCLK=LRCK=0 for WARMUP_MCLK*P cycles, then enter RUN with ph=0 and SLOT=0.
REQ-022 EN=0 during WARMUP SHALL return the block to IDLE on the next cycle.
REQ-023 In RUN/DRAIN, SCLK SHALL be 0 for ph < S/2 and 1 for ph >= S/2.
REQ-024 SLOT SHALL increment when ph wraps S-1 -> 0, and SHALL wrap 63 -> 0.
REQ-025 LRCK SHALL equal SLOT[5]: slots 0-31 left, 32-63 right.
REQ-026 SCLK_FALL SHALL assert in each RUN/DRAIN cycle with ph=0, including the first RUN cycle.
REQ-027 SCLK_RISE SHALL assert in each cycle with ph=S/2.
REQ-028 FRAME_START SHALL assert when SCLK_FALL=1 and SLOT=0.
REQ-029 EN=0 in RUN SHALL enter DRAIN; the current frame SHALL complete unchanged.
REQ-030 DRAIN at the end of slot 63 (ph=S-1) SHALL enter IDLE next cycle with all outputs 0.
REQ-031 EN=1 again during DRAIN SHALL return to RUN with no phase or slot discontinuity.
REQ-032 EN high and falling edge of frame in same cycle in DRAIN: EN wins, continue RUN.
REQ-033 RUNNING SHALL be 1 exactly in RUN and DRAIN.

Reset
REQ-034 RST=1 at any SYS_CLK edge SHALL force IDLE, ph=0, SLOT=0 and all outputs 0 on the next cycle, including mid-frame; RST has priority over EN.
REQ-035 After RST deasserts, behaviour SHALL be as from IDLE (REQ-019).

Structure
REQ-036 Package i2s_pkg SHALL hold the state enum, the default parameter values and the slot count constant 64.
REQ-037 No sub-module SHALL be used; ph, SLOT and the FSM live in one module.

Verification (defaults: P=4, S=16, frame = 1024 cycles, warmup = 128 cycles)
REQ-038 RST, then EN=1 -> MCLK period of 4 cycles starts at k+1; SCLK/LRCK stay 0 for 128 cycles; RUNNING=1 with FRAME_START in cycle k+129.
REQ-039 Steady run -> SCLK period 16 cycles, LRCK period 1024 cycles, 64 SCLK_RISE per frame, LRCK 1->0 coincides with FRAME_START.
REQ-040 EN=0 at SLOT=10 -> outputs continue to SLOT=63 ph=15, then IDLE with MCLK=0 next cycle.
REQ-041 EN=0 at SLOT=10, EN=1 at SLOT=40 -> no gap; next FRAME_START is exactly 1024 cycles after the previous one.
REQ-042 EN=0 after 50 warmup cycles -> IDLE next cycle, no SCLK edge ever seen.
REQ-043 RST at SLOT=33 ph=7 -> all outputs 0 next cycle; EN held at 1 -> a full 128-cycle warmup is repeated.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S clock sequencer: FSM states, default
// clock ratios and the fixed 64-slot frame length.
package i2s_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_RUN    = 2'd2,
      ST_DRAIN  = 2'd3
   } i2s_state_e;

   localparam int DEF_MCLK_DIV    = 2;
   localparam int DEF_SCLK_RATIO  = 4;
   localparam int DEF_WARMUP_MCLK = 32;

   localparam int SLOT_COUNT = 64;
   localparam int SLOT_W     = $clog2(SLOT_COUNT);

   // SCLK and LRCK toggle only in these two states.
   function automatic logic is_active(input i2s_state_e s);
      return (s == ST_RUN) || (s == ST_DRAIN);
   endfunction

endpackage

// File: rtl/i2s_clock_sequencer.sv
// Generates MCLK/SCLK/LRCK and bit-slot strobes for an I2S PMOD from SYS_CLK,
// with an MCLK-only warm-up and a frame-aligned shutdown.
module i2s_clock_sequencer
   import i2s_pkg::*;
#(
   parameter int MCLK_DIV    = DEF_MCLK_DIV,
   parameter int SCLK_RATIO  = DEF_SCLK_RATIO,
   parameter int WARMUP_MCLK = DEF_WARMUP_MCLK
) (
   input  logic       SYS_CLK,
   input  logic       RST,
   input  logic       EN,
   output logic       MCLK,
   output logic       SCLK,
   output logic       LRCK,
   output logic       SCLK_RISE,
   output logic       SCLK_FALL,
   output logic       FRAME_START,
   output logic [5:0] SLOT,
   output logic       RUNNING,
   output logic [1:0] dbg_state
);

   localparam int P        = 2 * MCLK_DIV;
   localparam int S        = P * SCLK_RATIO;
   localparam int HALF     = S / 2;
   localparam int WARM_LEN = WARMUP_MCLK * P;
   localparam int MC_W     = $clog2(P);
   localparam int PH_W     = $clog2(S);
   localparam int WARM_W   = $clog2(WARM_LEN);

   // EN is a level request, not a handshake: it is sampled on every SYS_CLK
   // edge and a drop only takes effect at a frame boundary once running.

   i2s_state_e              state_q, state_d;
   logic [PH_W-1:0]         ph_q, ph_d;
   logic [SLOT_W-1:0]       slot_q, slot_d;
   logic [WARM_W-1:0]       warm_q, warm_d;
   logic [MC_W-1:0]         mc_q, mc_d, mc_inc;
   logic                    ph_wrap;
   logic                    frame_end;
   logic                    active_d;
   logic                    clocking_d;

   logic                    mclk_d;
   logic                    sclk_d;
   logic                    lrck_d;
   logic                    sclk_rise_d;
   logic                    sclk_fall_d;
   logic                    frame_start_d;
   logic                    running_d;

   assign dbg_state = state_q;

   always_comb begin
      state_d   = state_q;
      ph_d      = ph_q;
      slot_d    = slot_q;
      warm_d    = warm_q;
      mc_d      = mc_q;
      mc_inc    = (mc_q == MC_W'(P - 1)) ? '0 : mc_q + 1'b1;
      ph_wrap   = (ph_q == PH_W'(S - 1));
      frame_end = ph_wrap && (slot_q == SLOT_W'(SLOT_COUNT - 1));

      case (state_q)
         ST_IDLE: begin
            ph_d   = '0;
            slot_d = '0;
            warm_d = '0;
            mc_d   = '0;
            if (EN) begin
               state_d = ST_WARMUP;
            end
         end

         ST_WARMUP: begin
            if (!EN) begin
               state_d = ST_IDLE;
               ph_d    = '0;
               slot_d  = '0;
               warm_d  = '0;
               mc_d    = '0;
            end else begin
               mc_d = mc_inc;
               // Warm-up length is a whole number of MCLK periods, so mc is
               // back at 0 exactly when the first slot begins.
               if (warm_q == WARM_W'(WARM_LEN - 1)) begin
                  state_d = ST_RUN;
                  warm_d  = '0;
                  ph_d    = '0;
                  slot_d  = '0;
               end else begin
                  warm_d = warm_q + 1'b1;
               end
            end
         end

         ST_RUN, ST_DRAIN: begin
            if (frame_end && !EN) begin
               state_d = ST_IDLE;
               ph_d    = '0;
               slot_d  = '0;
               warm_d  = '0;
               mc_d    = '0;
            end else begin
               mc_d    = mc_inc;
               ph_d    = ph_wrap ? '0 : ph_q + 1'b1;
               slot_d  = ph_wrap ? slot_q + 1'b1 : slot_q;
               state_d = EN ? ST_RUN : ST_DRAIN;
            end
         end

         default: begin
            state_d = ST_IDLE;
            ph_d    = '0;
            slot_d  = '0;
            warm_d  = '0;
            mc_d    = '0;
         end
      endcase

      // Outputs are decoded from the next state so the output flops line up
      // with the state they describe.
      active_d      = is_active(state_d);
      clocking_d    = active_d || (state_d == ST_WARMUP);
      mclk_d        = clocking_d && (mc_d >= MC_W'(MCLK_DIV));
      sclk_d        = active_d && (ph_d >= PH_W'(HALF));
      lrck_d        = active_d && slot_d[SLOT_W-1];
      sclk_rise_d   = active_d && (ph_d == PH_W'(HALF));
      sclk_fall_d   = active_d && (ph_d == '0);
      frame_start_d = sclk_fall_d && (slot_d == '0);
      running_d     = active_d;
   end

   always_ff @(posedge SYS_CLK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         ph_q        <= '0;
         slot_q      <= '0;
         warm_q      <= '0;
         mc_q        <= '0;
         MCLK        <= 1'b0;
         SCLK        <= 1'b0;
         LRCK        <= 1'b0;
         SCLK_RISE   <= 1'b0;
         SCLK_FALL   <= 1'b0;
         FRAME_START <= 1'b0;
         SLOT        <= '0;
         RUNNING     <= 1'b0;
      end else begin
         state_q     <= state_d;
         ph_q        <= ph_d;
         slot_q      <= slot_d;
         warm_q      <= warm_d;
         mc_q        <= mc_d;
         MCLK        <= mclk_d;
         SCLK        <= sclk_d;
         LRCK        <= lrck_d;
         SCLK_RISE   <= sclk_rise_d;
         SCLK_FALL   <= sclk_fall_d;
         FRAME_START <= frame_start_d;
         SLOT        <= active_d ? slot_d : '0;
         RUNNING     <= running_d;
      end
   end

endmodule

// File: tb/tb_i2s_clock_sequencer.sv
// Bench for i2s_clock_sequencer: an absolute-time model predicts every output
// each cycle, and directed scenarios pin latencies and frame timing.
module tb_i2s_clock_sequencer;

   localparam int DIV      = 2;
   localparam int P        = 2 * DIV;
   localparam int S        = P * 4;
   localparam int FRAME    = S * 64;
   localparam int WARM     = 32 * P;

   logic       clk;
   logic       rst;
   logic       en;
   logic       mclk, sclk, lrck, sclk_rise, sclk_fall, frame_start, running;
   logic [5:0] slot;
   logic [1:0] dbg_state;
   logic [12:0] outvec;

   int checks;
   int errors;

   i2s_clock_sequencer dut (
      .SYS_CLK     (clk),
      .RST         (rst),
      .EN          (en),
      .MCLK        (mclk),
      .SCLK        (sclk),
      .LRCK        (lrck),
      .SCLK_RISE   (sclk_rise),
      .SCLK_FALL   (sclk_fall),
      .FRAME_START (frame_start),
      .SLOT        (slot),
      .RUNNING     (running),
      .dbg_state   (dbg_state)
   );

   assign outvec = {mclk, sclk, lrck, sclk_rise, sclk_fall, frame_start, slot, running};

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model + scoreboard ----------------
   // mode 0 idle, 1 warm-up, 2 running; times are cycles since entry.
   int m_mode;
   int m_wt;
   int m_rt;
   int m_mt;
   logic [12:0] exp_q[$];

   function automatic logic [12:0] model_vec();
      int ph;
      int sl;
      logic [12:0] v;
      v = '0;
      if (m_mode != 0) v[12] = ((m_mt % P) >= DIV);
      if (m_mode == 2) begin
         ph    = m_rt % S;
         sl    = (m_rt / S) % 64;
         v[11] = (ph >= S / 2);
         v[10] = (sl >= 32);
         v[9]  = (ph == S / 2);
         v[8]  = (ph == 0);
         v[7]  = ((m_rt % FRAME) == 0);
         v[6:1] = sl[5:0];
         v[0]  = 1'b1;
      end
      return v;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_mode = 0;
      end else begin
         case (m_mode)
            0: if (en) begin m_mode = 1; m_wt = 0; m_mt = 0; end
            1: begin
               if (!en) m_mode = 0;
               else if (m_wt == WARM - 1) begin m_mode = 2; m_rt = 0; m_mt++; end
               else begin m_wt++; m_mt++; end
            end
            default: begin
               if (!en && (m_rt % FRAME) == FRAME - 1) m_mode = 0;
               else begin m_rt++; m_mt++; end
            end
         endcase
      end
      exp_q.push_back(model_vec());
   end

   always @(negedge clk) begin
      logic [12:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (outvec !== e) begin
            errors++;
            $display("FAIL cycle_outputs t=%0t got=%h expected=%h", $time, outvec, e);
         end
      end
   end

   // ---------------- driver / measurement tasks ----------------
   int   n_cyc, n_rise, n_fall, n_idle, n_sclk, n_mclk_rise;
   logic last_lrck;
   int   last_slot;
   logic last_sclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s timeout", name);
   endtask

   task automatic wait_fs(input int limit);
      logic found, prev_mclk, prev_lrck;
      n_cyc = 0; n_rise = 0; n_fall = 0; n_idle = 0; n_sclk = 0; n_mclk_rise = 0;
      prev_mclk = mclk;
      prev_lrck = lrck;
      last_lrck = lrck;
      found = 1'b0;
      while (!found && n_cyc < limit) begin
         @(negedge clk);
         n_cyc++;
         if (sclk_rise) n_rise++;
         if (sclk_fall) n_fall++;
         if (!running) n_idle++;
         if (mclk && !prev_mclk) n_mclk_rise++;
         if (frame_start) begin
            found = 1'b1;
            last_lrck = prev_lrck;
         end else if (sclk) n_sclk++;
         prev_mclk = mclk;
         prev_lrck = lrck;
      end
      if (!found) timeout("wait_frame_start");
   endtask

   task automatic wait_slot_fall(input int s, input int limit);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(slot == 6'(s) && sclk_fall) && n < limit);
      if (!(slot == 6'(s) && sclk_fall)) timeout("wait_slot_fall");
   endtask

   task automatic wait_idle(input int limit);
      n_cyc = 0;
      last_slot = -1;
      last_sclk = 1'b0;
      do begin
         @(negedge clk);
         n_cyc++;
         if (running) begin
            last_slot = slot;
            last_sclk = sclk;
         end
      end while (running && n_cyc < limit);
      if (running) timeout("wait_idle");
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      int   t0;
      logic mseen;
      checks = 0;
      errors = 0;
      m_mode = 0; m_wt = 0; m_rt = 0; m_mt = 0;
      rst = 1'b1;
      en  = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", outvec, 0);
      check("reset_state", dbg_state, 0);

      // Start-up: warm-up then first frame.
      rst = 1'b0;
      en  = 1'b1;
      wait_fs(400);
      check("warmup_latency", n_cyc, 129);
      check("warmup_no_sclk", n_sclk, 0);
      check("warmup_mclk_rises", n_mclk_rise, 32);
      check("first_frame_running", running, 1);

      // Steady state frame.
      wait_fs(1100);
      check("frame_period", n_cyc, FRAME);
      check("frame_sclk_rises", n_rise, 64);
      check("frame_sclk_falls", n_fall, 64);
      check("frame_mclk_rises", n_mclk_rise, FRAME / P);
      check("lrck_fall_at_frame_start", {last_lrck, lrck}, 2'b10);

      // Drain from slot 10 to end of frame.
      wait_slot_fall(10, 1100);
      en = 1'b0;
      wait_idle(1100);
      check("drain_cycles", n_cyc, FRAME - 10 * S);
      check("drain_last_slot", last_slot, 63);
      check("drain_last_sclk", last_sclk, 1);
      check("drain_idle_outputs", outvec, 0);

      // Re-enable, then drop and restore mid-frame.
      en = 1'b1;
      wait_fs(400);
      check("restart_latency", n_cyc, 129);
      t0 = int'($time);
      wait_slot_fall(10, 1100);
      en = 1'b0;
      wait_slot_fall(40, 1100);
      en = 1'b1;
      wait_fs(1100);
      check("restore_frame_period", (int'($time) - t0) / 10, FRAME);
      check("restore_no_gap", n_idle, 0);

      // Abort during warm-up.
      en = 1'b0;
      wait_idle(1100);
      en = 1'b1;
      n_sclk = 0;
      mseen = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (sclk || lrck || running) n_sclk++;
         if (mclk) mseen = 1'b1;
      end
      en = 1'b0;
      @(negedge clk);
      check("abort_idle_outputs", outvec, 0);
      check("abort_no_sclk", n_sclk, 0);
      check("abort_mclk_was_running", mseen, 1);
      repeat (10) @(negedge clk);

      // Reset mid-frame at slot 33, ph 7.
      en = 1'b1;
      wait_fs(400);
      wait_slot_fall(33, 1100);
      repeat (7) @(negedge clk);
      check("pre_reset_position", {slot, sclk, mclk}, {6'd33, 1'b0, 1'b1});
      rst = 1'b1;
      @(negedge clk);
      check("reset_midframe_outputs", outvec, 0);
      rst = 1'b0;
      wait_fs(400);
      check("rewarm_latency", n_cyc, 129);
      check("rewarm_no_sclk", n_sclk, 0);

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
